cpm_input: RTL and testbench

Receiving end of the 23-bit CPM result bus: bit 22 is the frame strobe, bits 21:0 carry a BCD-coded measurement. The block qualifies the strobe, captures and validates the BCD word, and converts it to binary over six cycles. It presents the binary result on a valid/ready handshake to the downstream logger. It also flags glitch, BCD-error, stuck-strobe and overrun conditions.

---
 rtl/cpm_input_pkg.sv | 48 ++++
 rtl/cpm_input_bcd_mac_step.sv | 16 +
 rtl/cpm_input.sv | 179 +++++++++++++++++
 tb/tb_cpm_input.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpm_input_pkg.sv
// Shared definitions for the CPM result-bus receiver: bus geometry,
// FSM state encoding and small BCD helpers.
package cpm_input_pkg;

    localparam int CPM_W          = 23;
    localparam int CPM_STROBE_BIT = 22;
    localparam int CPM_DATA_W     = 22;
    localparam int BIN_W          = 19;
    localparam int HI_CNT_W       = 12;
    localparam int CONV_STEPS     = 6;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_QUALIFY  = 3'd1,
        ST_CONVERT  = 3'd2,
        ST_HOLD     = 3'd3,
        ST_WAIT_LOW = 3'd4
    } cpm_state_t;

    // True when every 4-bit digit d4..d0 is a legal BCD value (0..9).
    // d5 is only 2 bits wide, so it can never be out of range.
    function automatic logic bcd_word_ok(input logic [CPM_DATA_W-1:0] w);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (w[i*4 +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // Digit fed to the accumulator on conversion step idx, most significant first.
    function automatic logic [3:0] conv_digit(input logic [CPM_DATA_W-1:0] w,
                                              input logic [2:0] idx);
        logic [3:0] d;
        case (idx)
            3'd0:    d = {2'b00, w[21:20]};
            3'd1:    d = w[19:16];
            3'd2:    d = w[15:12];
            3'd3:    d = w[11:8];
            3'd4:    d = w[7:4];
            default: d = w[3:0];
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cpm_input_bcd_mac_step.sv
// One decimal accumulation step: acc*10 + digit, built from shifts and adds
// so no multiplier is needed. Kept standalone for reuse by display paths.
module bcd_mac_step
    import cpm_input_pkg::*;
(
    input  logic [BIN_W-1:0] acc,
    input  logic [3:0]       digit,
    output logic [BIN_W-1:0] acc_next
);

    // acc*10 = acc*8 + acc*2, then add the incoming digit.
    always_comb begin
        acc_next = (acc << 3) + (acc << 1) + {{(BIN_W-4){1'b0}}, digit};
    end

endmodule

// File: rtl/cpm_input.sv
// Receiver for the 23-bit CPM result bus: qualifies the frame strobe,
// captures and validates the BCD word, converts it to binary over six
// cycles and offers the result to the logger.
//
// Result handshake: result_valid rises with result_bin and both stay stable
// until a cycle in which result_valid & result_ready are both 1; that cycle
// is the transfer and result_valid drops on the following edge.
module cpm_input
    import cpm_input_pkg::*;
#(
    parameter int MIN_HIGH = 16,
    parameter int MAX_HIGH = 4095
) (
    input  logic              clk_200MHz,
    input  logic              reset,
    input  logic [CPM_W-1:0]  cpm,
    input  logic              result_ready,
    output logic [BIN_W-1:0]  result_bin,
    output logic              result_valid,
    output logic              bcd_error,
    output logic              glitch,
    output logic              stuck_error,
    output logic              overrun,
    output cpm_state_t        fsm_state
);

    localparam logic [HI_CNT_W-1:0] MIN_LAST = HI_CNT_W'(MIN_HIGH - 1);
    localparam logic [HI_CNT_W-1:0] MAX_CNT  = HI_CNT_W'(MAX_HIGH);
    localparam logic [HI_CNT_W-1:0] MAX_PRE  = HI_CNT_W'(MAX_HIGH - 1);
    localparam logic [2:0]          LAST_STEP = 3'(CONV_STEPS - 1);

    cpm_state_t              state, next_state;
    logic                    strobe;
    logic                    strobe_d;
    logic                    strobe_d_vld;
    logic                    rise;
    logic [HI_CNT_W-1:0]     hi_cnt, hi_cnt_next;
    logic [CPM_DATA_W-1:0]   shadow;
    logic [BIN_W-1:0]        acc, acc_next;
    logic [2:0]              conv_step;
    logic [3:0]              digit;

    logic                    capture;
    logic                    bcd_bad;
    logic                    glitch_set;
    logic                    conv_done;
    logic                    accept;
    logic                    overrun_set;
    logic                    stuck_set;

    assign strobe    = cpm[CPM_STROBE_BIT];
    // strobe_d is meaningless on the first sample after reset, so a strobe
    // already high then is treated as mid-frame rather than as a rise.
    assign rise      = strobe & ~strobe_d & strobe_d_vld;
    assign digit     = conv_digit(shadow, conv_step);
    assign fsm_state = state;

    bcd_mac_step u_mac (
        .acc      (acc),
        .digit    (digit),
        .acc_next (acc_next)
    );

    // Strobe-high counter: counts in every state, saturates at MAX_HIGH.
    always_comb begin
        hi_cnt_next = '0;
        stuck_set   = 1'b0;
        if (strobe) begin
            hi_cnt_next = (hi_cnt == MAX_CNT) ? hi_cnt : hi_cnt + 1'b1;
            stuck_set   = (hi_cnt == MAX_PRE);
        end
    end

    // State register.
    always_ff @(posedge clk_200MHz) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and single-cycle control strobes.
    always_comb begin
        next_state  = state;
        capture     = 1'b0;
        bcd_bad     = 1'b0;
        glitch_set  = 1'b0;
        conv_done   = 1'b0;
        accept      = 1'b0;
        overrun_set = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    next_state = ST_QUALIFY;
                end else if (strobe) begin
                    next_state = ST_WAIT_LOW;
                end
            end
            ST_QUALIFY: begin
                if (!strobe) begin
                    glitch_set = 1'b1;
                    next_state = ST_IDLE;
                end else if (hi_cnt == MIN_LAST) begin
                    capture = 1'b1;
                    if (!bcd_word_ok(cpm[CPM_DATA_W-1:0])) begin
                        bcd_bad    = 1'b1;
                        next_state = ST_WAIT_LOW;
                    end else begin
                        next_state = ST_CONVERT;
                    end
                end
            end
            ST_CONVERT: begin
                if (conv_step == LAST_STEP) begin
                    conv_done  = 1'b1;
                    next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // A new frame while the old result is unread is dropped.
                overrun_set = rise;
                if (result_ready) begin
                    accept     = 1'b1;
                    next_state = strobe ? ST_WAIT_LOW : ST_IDLE;
                end
            end
            ST_WAIT_LOW: begin
                if (!strobe) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath: strobe history, counter, shadow capture, conversion, outputs.
    always_ff @(posedge clk_200MHz) begin
        if (reset) begin
            strobe_d     <= 1'b0;
            strobe_d_vld <= 1'b0;
            hi_cnt       <= '0;
            shadow       <= '0;
            acc          <= '0;
            conv_step    <= '0;
            result_bin   <= '0;
            result_valid <= 1'b0;
            bcd_error    <= 1'b0;
            glitch       <= 1'b0;
            stuck_error  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            strobe_d     <= strobe;
            strobe_d_vld <= 1'b1;
            hi_cnt       <= hi_cnt_next;
            bcd_error    <= bcd_bad;
            glitch       <= glitch_set;
            stuck_error  <= stuck_set;
            overrun      <= overrun_set;
            if (capture) begin
                shadow    <= cpm[CPM_DATA_W-1:0];
                acc       <= '0;
                conv_step <= '0;
            end else if (state == ST_CONVERT) begin
                acc       <= acc_next;
                conv_step <= conv_step + 3'd1;
            end
            if (conv_done) begin
                result_bin   <= acc_next;
                result_valid <= 1'b1;
            end else if (accept) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpm_input.sv
// Self-checking bench for cpm_input. Cycle numbers below are relative to
// cycle E, the cycle during which the strobe is first driven high; outputs
// observed just after the edge that ends cycle E+n-1 belong to cycle E+n.
module tb_cpm_input;
    import cpm_input_pkg::*;

    localparam int MIN_HIGH = 16;
    localparam int MAX_HIGH = 4095;

    logic              clk_200MHz = 1'b0;
    logic              reset;
    logic [CPM_W-1:0]  cpm;
    logic              result_ready;
    logic [BIN_W-1:0]  result_bin;
    logic              result_valid;
    logic              bcd_error;
    logic              glitch;
    logic              stuck_error;
    logic              overrun;
    cpm_state_t        fsm_state;

    int checks = 0;
    int errors = 0;

    // Event log filled by run_frame.
    int n_valid, first_valid, res_seen;
    int n_bcd, first_bcd, n_glitch, first_glitch, n_stuck, first_stuck, n_over;

    cpm_input #(.MIN_HIGH(MIN_HIGH), .MAX_HIGH(MAX_HIGH)) dut (
        .clk_200MHz   (clk_200MHz),
        .reset        (reset),
        .cpm          (cpm),
        .result_ready (result_ready),
        .result_bin   (result_bin),
        .result_valid (result_valid),
        .bcd_error    (bcd_error),
        .glitch       (glitch),
        .stuck_error  (stuck_error),
        .overrun      (overrun),
        .fsm_state    (fsm_state)
    );

    // Clock.
    always #5 clk_200MHz = ~clk_200MHz;

    task automatic step();
        @(posedge clk_200MHz);
        #1;
    endtask

    // Reference model: decimal value of a BCD word.
    function automatic int bcd_value(input logic [21:0] w);
        return int'(w[21:20]) * 100000 + int'(w[19:16]) * 10000 + int'(w[15:12]) * 1000
             + int'(w[11:8]) * 100 + int'(w[7:4]) * 10 + int'(w[3:0]);
    endfunction

    // Reference model: all lower five digits in 0..9.
    function automatic bit bcd_legal(input logic [21:0] w);
        logic [21:0] v;
        v = w;
        for (int i = 0; i < 5; i++) begin
            if (((v >> (4 * i)) & 22'hF) > 22'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Drive one frame with ready=1: strobe high for len cycles, observe total cycles.
    task automatic run_frame(input logic [21:0] data, input int len, input int total);
        n_valid = 0; first_valid = -1; res_seen = -1;
        n_bcd = 0; first_bcd = -1; n_glitch = 0; first_glitch = -1;
        n_stuck = 0; first_stuck = -1; n_over = 0;
        cpm = {1'b1, data};
        for (int n = 1; n <= total; n++) begin
            step();
            if (result_valid) begin
                n_valid++;
                if (first_valid < 0) first_valid = n;
                res_seen = int'(result_bin);
            end
            if (bcd_error) begin n_bcd++; if (first_bcd < 0) first_bcd = n; end
            if (glitch) begin n_glitch++; if (first_glitch < 0) first_glitch = n; end
            if (stuck_error) begin n_stuck++; if (first_stuck < 0) first_stuck = n; end
            if (overrun) n_over++;
            if (n >= len) cpm[CPM_STROBE_BIT] = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cpm = '0; result_ready = 1'b1;
        repeat (3) step();
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", result_valid); end
        checks++; if (result_bin !== '0) begin errors++; $display("FAIL reset_bin: got %0d want 0", result_bin); end
        checks++; if ({bcd_error, glitch, stuck_error, overrun} !== 4'b0) begin errors++; $display("FAIL reset_pulses: got %b want 0000", {bcd_error, glitch, stuck_error, overrun}); end
        reset = 1'b0;
        repeat (2) step();
        checks++; if (fsm_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", fsm_state, ST_IDLE); end
    endtask

    task automatic test_convert();
        run_frame(22'h299999, 1946, 1980);
        checks++; if (n_valid !== 1) begin errors++; $display("FAIL conv_valid_count: got %0d want 1", n_valid); end
        checks++; if (first_valid !== MIN_HIGH + 6) begin errors++; $display("FAIL conv_valid_cycle: got %0d want %0d", first_valid, MIN_HIGH + 6); end
        checks++; if (res_seen !== 299999) begin errors++; $display("FAIL conv_value: got %0d want 299999", res_seen); end
        checks++; if (n_bcd + n_glitch + n_stuck + n_over !== 0) begin errors++; $display("FAIL conv_no_errors: got %0d pulses want 0", n_bcd + n_glitch + n_stuck + n_over); end
        checks++; if (fsm_state !== ST_IDLE) begin errors++; $display("FAIL conv_end_state: got %0d want %0d", fsm_state, ST_IDLE); end
    endtask

    task automatic test_bcd_error();
        run_frame(22'h00A000, 100, 120);
        checks++; if (n_bcd !== 1) begin errors++; $display("FAIL bcd_count: got %0d want 1", n_bcd); end
        checks++; if (first_bcd !== MIN_HIGH) begin errors++; $display("FAIL bcd_cycle: got %0d want %0d", first_bcd, MIN_HIGH); end
        checks++; if (n_valid !== 0) begin errors++; $display("FAIL bcd_no_valid: got %0d want 0", n_valid); end
    endtask

    task automatic test_glitch();
        run_frame(22'h000042, 5, 10);
        checks++; if (n_glitch !== 1) begin errors++; $display("FAIL glitch_count: got %0d want 1", n_glitch); end
        checks++; if (first_glitch !== 6) begin errors++; $display("FAIL glitch_cycle: got %0d want 6", first_glitch); end
        checks++; if (fsm_state !== ST_IDLE) begin errors++; $display("FAIL glitch_state: got %0d want %0d", fsm_state, ST_IDLE); end
        checks++; if (n_valid !== 0) begin errors++; $display("FAIL glitch_no_valid: got %0d want 0", n_valid); end
        run_frame(22'h000042, 30, 50);
        checks++; if (res_seen !== 42) begin errors++; $display("FAIL glitch_next_value: got %0d want 42", res_seen); end
        checks++; if (first_valid !== MIN_HIGH + 6) begin errors++; $display("FAIL glitch_next_cycle: got %0d want %0d", first_valid, MIN_HIGH + 6); end
    endtask

    task automatic test_stuck();
        run_frame(22'h000001, 5000, 5010);
        checks++; if (res_seen !== 1) begin errors++; $display("FAIL stuck_value: got %0d want 1", res_seen); end
        checks++; if (first_valid !== MIN_HIGH + 6) begin errors++; $display("FAIL stuck_valid_cycle: got %0d want %0d", first_valid, MIN_HIGH + 6); end
        checks++; if (n_stuck !== 1) begin errors++; $display("FAIL stuck_count: got %0d want 1", n_stuck); end
        checks++; if (first_stuck !== MAX_HIGH) begin errors++; $display("FAIL stuck_cycle: got %0d want %0d", first_stuck, MAX_HIGH); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 12; k++) begin
            logic [21:0] data;
            int len, exp_val;
            bit legal, exp_glitch;
            data = {2'($urandom_range(0, 3)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                    4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            if ($urandom_range(0, 3) == 0) begin
                int pos;
                pos = $urandom_range(0, 4);
                data[pos*4 +: 4] = 4'($urandom_range(10, 15));
            end
            len = $urandom_range(1, 40);
            run_frame(data, len, 60);
            legal      = bcd_legal(data);
            exp_glitch = (len < MIN_HIGH);
            exp_val    = bcd_value(data);
            checks++; if (n_glitch !== int'(exp_glitch)) begin errors++; $display("FAIL rand_glitch[%0d]: got %0d want %0d (len %0d)", k, n_glitch, exp_glitch, len); end
            checks++; if (n_bcd !== int'(!exp_glitch && !legal)) begin errors++; $display("FAIL rand_bcd[%0d]: got %0d want %0d (data %h)", k, n_bcd, !exp_glitch && !legal, data); end
            checks++; if (n_valid !== int'(!exp_glitch && legal)) begin errors++; $display("FAIL rand_valid[%0d]: got %0d want %0d", k, n_valid, !exp_glitch && legal); end
            if (!exp_glitch && legal) begin
                checks++; if (res_seen !== exp_val) begin errors++; $display("FAIL rand_value[%0d]: got %0d want %0d (data %h)", k, res_seen, exp_val, data); end
                checks++; if (first_valid !== MIN_HIGH + 6) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", k, first_valid, MIN_HIGH + 6); end
            end
            if (exp_glitch) begin
                checks++; if (first_glitch !== len + 1) begin errors++; $display("FAIL rand_glitch_cycle[%0d]: got %0d want %0d", k, first_glitch, len + 1); end
            end
        end
    endtask

    task automatic test_back_to_back_overrun();
        int over_cnt, over_cycle, unstable, valid_after;
        over_cnt = 0; over_cycle = -1; unstable = 0; valid_after = 0;
        result_ready = 1'b0;
        cpm = {1'b1, 22'h000123};
        for (int n = 1; n <= 70; n++) begin
            step();
            if (n >= MIN_HIGH + 6 && (result_valid !== 1'b1 || result_bin !== 19'd123)) unstable++;
            if (overrun) begin over_cnt++; if (over_cycle < 0) over_cycle = n; end
            if (n == 30) cpm[CPM_STROBE_BIT] = 1'b0;
            if (n == 40) cpm = {1'b1, 22'h000456};
            if (n == 60) cpm[CPM_STROBE_BIT] = 1'b0;
        end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL ovr_hold_stable: got %0d bad cycles want 0", unstable); end
        checks++; if (over_cnt !== 1) begin errors++; $display("FAIL ovr_count: got %0d want 1", over_cnt); end
        checks++; if (over_cycle !== 41) begin errors++; $display("FAIL ovr_cycle: got %0d want 41", over_cycle); end
        result_ready = 1'b1;
        step();
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept: got %0b want 0", result_valid); end
        for (int n = 0; n < 40; n++) begin
            step();
            if (result_valid) valid_after++;
        end
        checks++; if (valid_after !== 0) begin errors++; $display("FAIL ovr_dropped: got %0d valid cycles want 0", valid_after); end
        checks++; if (result_bin !== 19'd123) begin errors++; $display("FAIL ovr_bin_kept: got %0d want 123", result_bin); end
    endtask

    task automatic test_reset_mid_convert();
        int valid_cnt;
        valid_cnt = 0;
        cpm = {1'b1, 22'h000777};
        repeat (MIN_HIGH + 3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (result_valid !== 1'b0 || result_bin !== '0) begin errors++; $display("FAIL rst_mid_outputs: got valid %0b bin %0d want 0 0", result_valid, result_bin); end
        checks++; if ({bcd_error, glitch, stuck_error, overrun} !== 4'b0) begin errors++; $display("FAIL rst_mid_pulses: got %b want 0000", {bcd_error, glitch, stuck_error, overrun}); end
        checks++; if (fsm_state !== ST_IDLE) begin errors++; $display("FAIL rst_mid_state: got %0d want %0d", fsm_state, ST_IDLE); end
        step();
        checks++; if (fsm_state !== ST_WAIT_LOW) begin errors++; $display("FAIL rst_mid_wait_low: got %0d want %0d", fsm_state, ST_WAIT_LOW); end
        for (int n = 0; n < 40; n++) begin
            step();
            if (result_valid) valid_cnt++;
        end
        checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL rst_mid_no_result: got %0d valid cycles want 0", valid_cnt); end
        cpm[CPM_STROBE_BIT] = 1'b0;
        repeat (5) step();
        run_frame(22'h000777, 30, 50);
        checks++; if (res_seen !== 777) begin errors++; $display("FAIL rst_mid_fresh: got %0d want 777", res_seen); end
    endtask

    initial begin
        reset = 1'b1;
        cpm = '0;
        result_ready = 1'b1;
        test_reset();
        test_convert();
        test_bcd_error();
        test_glitch();
        test_stuck();
        test_random();
        test_back_to_back_overrun();
        test_reset_mid_convert();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
